// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: operation codes,
// FSM state encoding and default datapath widths.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  // Low two bits of funct3 for the M-extension divide group.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    SPEC = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem      partial remainder (WIDTH+1 bits)
//   quo      dividend/quotient shift register
//   divisor  divisor magnitude
//   rem_next partial remainder after the step
//   quo_next quotient register after the step (new bit in the LSB)
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvsr_ext;
  logic             fits;

  // Shift {rem, quo} left, then subtract when the divisor fits. The
  // compare is done one bit wider than rem so it can never wrap.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    dvsr_ext = {2'b00, divisor};
    fits     = (shifted >= dvsr_ext);
    rem_next = fits ? (WIDTH+1)'(shifted - dvsr_ext) : (WIDTH+1)'(shifted);
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle EX-stage divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-low reset
//   start_i   request pulse, accepted only while busy_o=0
//   op_i      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   data1_i   dividend
//   data2_i   divisor
//   busy_o    high from the cycle after acceptance through the done cycle
//   done_o    one-cycle pulse, result_o valid
//   result_o  quotient or remainder, held until the next result
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             rem_sel_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             signed_op;
  logic             rem_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;
  logic             special;
  logic [WIDTH-1:0] spec_quo;
  logic [WIDTH-1:0] spec_rem;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  // Operand decode, magnitude conversion and special-case detection.
  always_comb begin
    signed_op = (op_i == OP_DIV) || (op_i == OP_REM);
    rem_op    = (op_i == OP_REM) || (op_i == OP_REMU);
    a_neg     = signed_op && data1_i[WIDTH-1];
    b_neg     = signed_op && data2_i[WIDTH-1];
    a_mag     = a_neg ? (WIDTH'(0) - data1_i) : data1_i;
    b_mag     = b_neg ? (WIDTH'(0) - data2_i) : data2_i;
    div_zero  = (data2_i == '0);
    overflow  = signed_op && (data1_i == MIN_NEG) && (data2_i == ALL_ONES);
    special   = div_zero || overflow;
    spec_quo  = div_zero ? ALL_ONES : MIN_NEG;
    spec_rem  = div_zero ? data1_i : '0;
  end

  // Sign correction of the raw magnitude results.
  always_comb begin
    fix_quo = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
    fix_rem = neg_rem_q ? (WIDTH'(0) - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvsr_q),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );

  // Control FSM and datapath registers. Special cases preload quo/rem
  // with their final values so SPEC only has to select one of them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_o    <= 1'b1;
            rem_sel_q <= rem_op;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dvsr_q    <= b_mag;
            if (special) begin
              quo_q   <= spec_quo;
              rem_q   <= {1'b0, spec_rem};
              state_q <= SPEC;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= '0;
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FIX: begin
          result_o <= rem_sel_q ? fix_rem : fix_quo;
          done_o   <= 1'b1;
          state_q  <= DONE;
        end
        SPEC: begin
          result_o <= rem_sel_q ? rem_q[WIDTH-1:0] : quo_q;
          done_o   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: latency, results, special cases,
// ignored start while busy and reset abort.
module tb_div_unit;
  import div_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int total;
  int bad;

  div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request at the falling edge; it is accepted at the next rising
  // edge (cycle 0), after which start_i is dropped.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    data1_i = a;
    data2_i = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    data1_i = 32'h0;
    data2_i = 32'h0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int          lat;
    int          pulses;
    logic [31:0] res;
    logic        busy1;
    lat    = -1;
    pulses = 0;
    res    = 32'h0;
    busy1  = 1'b0;
    issue(op, a, b);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      if (n == 1) busy1 = busy_o;
      if (done_o) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          res = result_o;
        end
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, res, exp);
    check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
    check_eq({tag, "_busy1"}, {31'h0, busy1}, 32'd1);
    check_eq({tag, "_held"}, result_o, exp);
    check_eq({tag, "_idle"}, {31'h0, busy_o}, 32'd0);
  endtask

  initial begin
    int          lat;
    int          pulses;
    logic [31:0] res;

    total   = 0;
    bad     = 0;
    rst_i   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    data1_i = 32'h0;
    data2_i = 32'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_busy", {31'h0, busy_o}, 32'd0);
    check_eq("rst_done", {31'h0, done_o}, 32'd0);
    check_eq("rst_result", result_o, 32'h0);
    rst_i = 1'b1;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run_op("divu_min_max", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 2);
    run_op("rem_m7_0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    // A second start while busy must be dropped, not queued.
    lat    = -1;
    pulses = 0;
    res    = 32'h0;
    issue(OP_DIVU, 32'd9, 32'd3);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      if (n == 10) begin
        start_i = 1'b1;
        op_i    = OP_DIVU;
        data1_i = 32'd8;
        data2_i = 32'd2;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          res = result_o;
        end
      end
    end
    check_eq("busy_start_lat", 32'(lat), 32'd34);
    check_eq("busy_start_res", res, 32'd3);
    check_eq("busy_start_pulses", 32'(pulses), 32'd1);

    // Reset in the middle of an operation aborts it.
    issue(OP_DIVU, 32'd50, 32'd5);
    pulses = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk_i);
      if (done_o) pulses++;
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("abort_busy", {31'h0, busy_o}, 32'd0);
    check_eq("abort_result", result_o, 32'h0);
    check_eq("abort_done", {31'h0, done_o}, 32'd0);
    rst_i = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (done_o) pulses++;
    end
    check_eq("abort_pulses", 32'(pulses), 32'd0);

    run_op("after_abort", OP_DIVU, 32'd50, 32'd5, 32'd10, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
